// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding I-mem request at a time, 1-entry skid plus output slot, squashes on redirect.
// Data reaches instrF one cycle after mem_ready; under StallD two instructions are held, then mem_req drops.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] JumpAdd,
  input  logic        StallD,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] pc_plus4F,
  output logic        validF,
  output logic        StallF
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        skid_valid;
  logic [31:0] redir_target;
  logic [31:0] pc_next4;
  logic        redirect;
  logic        consume;
  logic        fetch_req;
  logic        accept;
  logic        outstanding;

  assign redirect    = (PCSrcD != 2'b00);
  assign consume     = validF & ~StallD;
  assign fetch_req   = (state == FETCH) & ~skid_valid;
  assign accept      = fetch_req & mem_ready;
  assign outstanding = fetch_req & ~mem_ready;
  assign pc_next4    = pc + 32'd4;

  always_comb begin
    redir_target = RESET_PC;
    case (PCSrcD)
      2'b01:   redir_target = PCBranchD;
      2'b10:   redir_target = JumpAdd;
      default: redir_target = RESET_PC;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = pc;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        mem_req = fetch_req;
        if (redirect && outstanding) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The stale request must complete at its original address before the new pc is fetched.
        mem_req  = 1'b1;
        mem_addr = drain_addr;
        if (mem_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    StallF = (state == DRAIN) | (mem_req & ~mem_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      skid_instr <= 32'd0;
      skid_pc4   <= 32'd0;
      skid_valid <= 1'b0;
      instrF     <= 32'd0;
      pc_plus4F  <= 32'd0;
      validF     <= 1'b0;
    end else if (redirect) begin
      pc         <= {redir_target[31:2], 2'b00};
      validF     <= 1'b0;
      skid_valid <= 1'b0;
      if (outstanding) drain_addr <= pc;
    end else if (accept) begin
      pc <= pc_next4;
      if (!validF || consume) begin
        instrF    <= mem_rdata;
        pc_plus4F <= pc_next4;
        validF    <= 1'b1;
      end else begin
        skid_instr <= mem_rdata;
        skid_pc4   <= pc_next4;
        skid_valid <= 1'b1;
      end
    end else if (consume) begin
      // No response this cycle, so mem_req was low or waiting: refill the slot from the skid if it holds one.
      if (skid_valid) begin
        instrF     <= skid_instr;
        pc_plus4F  <= skid_pc4;
        skid_valid <= 1'b0;
      end else begin
        validF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed timing scenarios plus random stall/redirect/latency traffic,
// checked against an architectural model of the expected instruction stream.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] JumpAdd;
  logic        StallD;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instrF;
  logic [31:0] pc_plus4F;
  logic        validF;
  logic        StallF;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .JumpAdd   (JumpAdd),
    .StallD    (StallD),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .instrF    (instrF),
    .pc_plus4F (pc_plus4F),
    .validF    (validF),
    .StallF    (StallF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait_mode;
  int          wait_cnt;
  int          cur_wait;
  int          idle;
  logic        stray_en;
  logic        force_stray;
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic int next_wait();
    if (wait_mode < 0) return int'($urandom_range(0, 3));
    return wait_mode;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | {28'd0, t[3:0]};
    return t;
  endfunction

  function automatic logic [31:0] redirect_target();
    case (PCSrcD)
      2'b01:   return PCBranchD;
      2'b10:   return JumpAdd;
      default: return RESET_PC;
    endcase
  endfunction

  task automatic model_init();
    exp_pc    = RESET_PC;
    wait_cnt  = 0;
    cur_wait  = next_wait();
    prev_wait = 1'b0;
    prev_addr = RESET_PC;
    idle      = 0;
  endtask

  // Called at posedge+1: drive the memory response, then check the settled cycle.
  task automatic begin_cycle();
    if (mem_req) begin
      if (wait_cnt >= cur_wait) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
        cur_wait  = next_wait();
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      mem_ready = force_stray || (stray_en && ($urandom_range(0, 3) == 0));
      mem_rdata = $urandom;
    end
    #1;
    if (prev_wait) chk_eq("addr_stable", mem_addr, prev_addr);
    if (mem_req && !mem_ready) chk_eq("stallf_wait", 32'(StallF), 1);
    if (!mem_req) chk_eq("stallf_noreq", 32'(StallF), 0);
    if (PCSrcD != 2'b00) begin
      exp_pc = redirect_target() & 32'hFFFF_FFFC;
      idle   = 0;
    end else if (validF && !StallD) begin
      chk_eq("stream_instr", instrF, mem_word(exp_pc));
      chk_eq("stream_pc4", pc_plus4F, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      idle   = 0;
    end else if (!StallD) begin
      idle++;
      if (idle > 40) begin
        chk_eq("progress", idle, 0);
        idle = 0;
      end
    end
    prev_wait = mem_req && !mem_ready;
    prev_addr = mem_addr;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    PCSrcD = 2'b00;
  endtask

  task automatic step();
    begin_cycle();
    end_cycle();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    PCSrcD      = 2'b00;
    StallD      = 1'b0;
    mem_ready   = 1'b0;
    force_stray = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_eq("rst_validF", 32'(validF), 0);
    chk_eq("rst_instrF", instrF, 0);
    chk_eq("rst_pc4", pc_plus4F, 0);
    chk_eq("rst_mem_req", 32'(mem_req), 0);
    chk_eq("rst_mem_addr", mem_addr, RESET_PC);
    chk_eq("rst_StallF", 32'(StallF), 0);
    rst = 1'b0;
    model_init();
  endtask

  initial begin
    int n;
    rst = 1'b1; PCSrcD = 2'b00; PCBranchD = 32'd0; JumpAdd = 32'd0; StallD = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'd0; stray_en = 1'b0; force_stray = 1'b0; wait_mode = 0;

    // Zero-wait streaming
    wait_mode = 0;
    do_reset();
    begin_cycle(); chk_eq("idle_noreq", 32'(mem_req), 0); end_cycle();
    begin_cycle();
    chk_eq("first_req", 32'(mem_req), 1);
    chk_eq("first_addr", mem_addr, RESET_PC);
    chk_eq("first_vld", 32'(validF), 0);
    end_cycle();
    for (int k = 0; k < 3; k++) begin
      begin_cycle();
      chk_eq("zw_vld", 32'(validF), 1);
      chk_eq("zw_instr", instrF, mem_word(4 * k));
      chk_eq("zw_pc4", pc_plus4F, 4 * k + 4);
      end_cycle();
    end

    // Two wait states: StallF high two of every three cycles
    wait_mode = 2;
    do_reset();
    step();
    for (int k = 1; k < 10; k++) begin
      begin_cycle();
      chk_eq("w2_req", 32'(mem_req), 1);
      chk_eq("w2_stallf", 32'(StallF), ((k % 3) != 0) ? 1 : 0);
      chk_eq("w2_addr", mem_addr, ((k - 1) / 3) * 4);
      end_cycle();
    end

    // Decode stall fills slot and skid, then release
    wait_mode = 0;
    do_reset();
    step(); step();
    StallD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      begin_cycle();
      chk_eq("hold_instr", instrF, mem_word(0));
      if (k > 0) chk_eq("hold_noreq", 32'(mem_req), 0);
      end_cycle();
    end
    StallD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      begin_cycle();
      chk_eq("release_vld", 32'(validF), 1);
      chk_eq("release_instr", instrF, mem_word(4 * k));
      end_cycle();
    end

    // Branch while a 3-wait request at 0x10 is outstanding
    wait_mode = 0;
    do_reset();
    for (int i = 0; i < 20 && mem_addr != 32'h0000_000C; i++) step();
    chk_eq("reach_0c", mem_addr, 32'h0000_000C);
    wait_mode = 3;
    step();
    begin_cycle();
    chk_eq("wait_10_addr", mem_addr, 32'h10);
    chk_eq("wait_10_stall", 32'(StallF), 1);
    end_cycle();
    PCSrcD = 2'b01; PCBranchD = 32'h40;
    step();
    wait_mode = 0;
    n = 0;
    while (mem_addr == 32'h10 && n < 10) begin
      begin_cycle();
      chk_eq("drain_vld", 32'(validF), 0);
      chk_eq("drain_stall", 32'(StallF), 1);
      chk_eq("drain_req", 32'(mem_req), 1);
      end_cycle();
      n++;
    end
    chk_eq("drain_len", n, 2);
    begin_cycle();
    chk_eq("br_addr", mem_addr, 32'h40);
    chk_eq("br_vld", 32'(validF), 0);
    end_cycle();
    begin_cycle();
    chk_eq("br_vld2", 32'(validF), 1);
    chk_eq("br_instr", instrF, mem_word(32'h40));
    end_cycle();

    // Jump in the same cycle as mem_ready, unaligned target
    wait_mode = 0;
    do_reset();
    step(); step(); step();
    PCSrcD = 2'b10; JumpAdd = 32'h103;
    begin_cycle(); chk_eq("jmp_req", 32'(mem_req), 1); end_cycle();
    begin_cycle();
    chk_eq("jmp_addr", mem_addr, 32'h100);
    chk_eq("jmp_vld", 32'(validF), 0);
    end_cycle();
    begin_cycle();
    chk_eq("jmp_instr", instrF, mem_word(32'h100));
    chk_eq("jmp_pc4", pc_plus4F, 32'h104);
    end_cycle();

    // Reset during a wait, stray mem_ready in IDLE
    wait_mode = 3;
    do_reset();
    step();
    begin_cycle();
    chk_eq("pre_rst_req", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk_eq("midrst_req", 32'(mem_req), 0);
    chk_eq("midrst_addr", mem_addr, RESET_PC);
    chk_eq("midrst_vld", 32'(validF), 0);
    chk_eq("midrst_instr", instrF, 0);
    chk_eq("midrst_pc4", pc_plus4F, 0);
    chk_eq("midrst_stallf", 32'(StallF), 0);
    end_cycle();
    rst = 1'b0;
    model_init();
    force_stray = 1'b1;
    begin_cycle(); chk_eq("postrst_idle_req", 32'(mem_req), 0); end_cycle();
    force_stray = 1'b0;
    begin_cycle();
    chk_eq("postrst_addr", mem_addr, RESET_PC);
    chk_eq("postrst_req", 32'(mem_req), 1);
    chk_eq("postrst_vld", 32'(validF), 0);
    end_cycle();
    for (int i = 0; i < 10; i++) step();

    // Random latency, stalls, redirects and stray responses
    wait_mode = -1;
    stray_en  = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      StallD = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        PCSrcD    = 2'($urandom_range(1, 3));
        PCBranchD = pick_target();
        JumpAdd   = pick_target();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch over a handshaked, variable-latency instruction memory and replaces the free-running PC/memory path of the fetch stage. The block holds the PC and issues one outstanding memory request at a time. It buffers returned instructions against decode back-pressure and squashes in-flight fetches on branch or jump redirects from decode. It presents instrF/pc_plus4F/validF to the IF/ID register and StallF to the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; also the target for PCSrcD = 2'b11
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- PCSrcD  input  2  redirect select from decode: 00 none, 01 PCBranchD, 10 JumpAdd, 11 RESET_PC
- PCBranchD  input  32  branch target
- JumpAdd  input  32  jump target
- StallD  input  1  decode cannot accept instrF this cycle
- mem_req  output  1  instruction memory request
- mem_addr  output  32  request address, word aligned
- mem_ready  input  1  response strobe; mem_rdata valid this cycle
- mem_rdata  input  32  instruction word
- instrF  output  32  fetched instruction
- pc_plus4F  output  32  address of instrF + 4
- validF  output  1  instrF/pc_plus4F hold a live instruction
- StallF  output  1  fetch waiting on memory (mem_req & !mem_ready)

## Operation
- State register values: IDLE, FETCH, DRAIN. Datapath registers: pc, a 1-entry skid buffer (skid_instr, skid_pc4, skid_valid), and the output slot (instrF, pc_plus4F, validF).
- The slot is consumed in a cycle when validF & !StallD.
- Reset (async): state=IDLE, pc=RESET_PC, skid_valid=0, validF=0, instrF=0, pc_plus4F=0, mem_req=0, mem_addr=RESET_PC, StallF=0.
- IDLE: one cycle with no request, then go to FETCH.
- FETCH: mem_req = !skid_valid. mem_addr = pc, held stable until mem_ready. mem_ready is ignored while mem_req=0.
- FETCH, mem_ready, no redirect:
  - If the slot is empty or consumed, rdata goes to the slot (pc_plus4F = pc+4, validF = 1).
  - Otherwise rdata goes to the skid buffer.
  - In both cases pc <= pc+4.
- Slot consumed with skid_valid: the skid contents move to the slot and skid_valid clears. A same-cycle mem_ready is impossible here because mem_req=0.
- Slot consumed with no new data: validF <= 0.
- Redirect (PCSrcD != 00) takes priority over every other event, including StallD:
  - pc <= target with bits [1:0] forced to 00.
  - validF <= 0 and skid_valid <= 0.
  - If a request is outstanding (FETCH, mem_req=1, mem_ready=0), go to DRAIN. Otherwise stay in FETCH and request the target next cycle.
  - If mem_ready arrives in the same cycle, the data is discarded.
- DRAIN: mem_req=1 and mem_addr = the stale address until mem_ready. The response is discarded, then go to FETCH at the new pc. A further redirect in DRAIN updates pc and stays in DRAIN. StallF=1 throughout DRAIN.
- Arithmetic: all PC math is 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0. The skid stores pc+4 computed at capture time.

## Timing
- First request is in the cycle after the reset release (IDLE), so mem_req rises in the second cycle.
- With a zero-wait memory (mem_ready in the same cycle as mem_req) and StallD=0, throughput is one instruction per cycle. validF rises one cycle after the response.
- N wait states add N cycles per instruction; StallF is high for exactly those N cycles.
- Back-pressure holds at most two instructions (slot + skid). mem_req deasserts in the cycle after the skid fills.
- Redirect-to-request latency: 1 cycle if no request is outstanding, otherwise the remaining memory latency + 1.
- Reset asserted mid-request: mem_req drops immediately. Any late response is ignored because mem_req=0 in IDLE.
- mem_addr never changes while mem_req=1 and mem_ready=0.

## Test plan
- Zero-wait memory, StallD=0, RESET_PC=0: instrF sequence mem[0], mem[4], mem[8] on consecutive cycles; pc_plus4F = 4, 8, 12; validF stays high.
- 2-wait-state memory: each instruction takes 3 cycles; StallF high 2 of 3 cycles; mem_addr stable while waiting.
- Hold StallD=1 for 5 cycles while streaming: slot and skid fill, mem_req drops, and instrF is unchanged. On release, instrF delivers the slot, then the skid, then resumes fetching with no instruction lost or duplicated.
- PCSrcD=01, PCBranchD=32'h40 while a 3-wait request at 32'h10 is outstanding: DRAIN until ready; the 32'h10 data never appears; the next mem_addr is 32'h40; validF=0 until the 32'h40 data returns.
- Redirect PCSrcD=10 with JumpAdd=32'h103 in the same cycle as mem_ready: data discarded; the next mem_addr is 32'h100.
- Assert rst mid-wait, then release: all outputs return to reset values immediately; the first mem_addr after release is RESET_PC; a stray mem_ready during IDLE is ignored.
